// File: rtl/zcore_data_mem_if.sv
// Load/store port bundle between the ZCore core (master) and its data memory (slave).
// Signal names keep the memory's point of view: _i driven by the core, _o by the memory.
interface zcore_data_mem_if #(
    parameter int unsigned DM_WIDTH = 32
) ();
    logic                    dm_wr_en_i;
    logic [DM_WIDTH-1:0]     dm_wr_addr_i;
    logic [DM_WIDTH-1:0]     dm_wr_data_i;
    logic [DM_WIDTH/8-1:0]   dm_wr_strb_i;
    logic                    dm_wr_err_o;
    logic                    dm_rd_en_i;
    logic [DM_WIDTH-1:0]     dm_rd_addr_i;
    logic [DM_WIDTH-1:0]     dm_rd_data_o;
    logic                    dm_rd_valid_o;
    logic                    dm_rd_err_o;
    logic                    dm_rd_par_err_o;
    logic                    dm_par_inject_i;

    modport master (
        output dm_wr_en_i, dm_wr_addr_i, dm_wr_data_i, dm_wr_strb_i, dm_rd_en_i, dm_rd_addr_i,
               dm_par_inject_i,
        input  dm_wr_err_o, dm_rd_data_o, dm_rd_valid_o, dm_rd_err_o, dm_rd_par_err_o
    );

    modport slave (
        input  dm_wr_en_i, dm_wr_addr_i, dm_wr_data_i, dm_wr_strb_i, dm_rd_en_i, dm_rd_addr_i,
               dm_par_inject_i,
        output dm_wr_err_o, dm_rd_data_o, dm_rd_valid_o, dm_rd_err_o, dm_rd_par_err_o
    );
endinterface

// File: rtl/zcore_data_mem.sv
// ZCore data memory: byte-strobed writes, pipelined reads with DM_RD_LAT cycles of latency,
// range/alignment checking against DM_BASE_ADDR. Define DM_PARITY_EN to add per-byte even
// parity storage and read-side parity checking.
module zcore_data_mem #(
    parameter int unsigned          DM_WIDTH     = 32,
    parameter int unsigned          DM_DEPTH     = 1024,
    parameter logic [DM_WIDTH-1:0]  DM_BASE_ADDR = 32'h0004_8120,
    parameter int unsigned          DM_RD_LAT    = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    zcore_data_mem_if.slave         dm
);
    localparam int unsigned AW   = $clog2(DM_DEPTH);
    localparam int unsigned NB   = DM_WIDTH / 8;
    localparam int unsigned Last = DM_RD_LAT - 1;

    if (DM_WIDTH != 32) begin : g_chk_width
        $error("zcore_data_mem: DM_WIDTH must be 32");
    end
    if (DM_RD_LAT < 1 || DM_RD_LAT > 4) begin : g_chk_lat
        $error("zcore_data_mem: DM_RD_LAT must be in 1..4");
    end
    if (DM_DEPTH < 16 || DM_DEPTH > 65536 || (DM_DEPTH & (DM_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("zcore_data_mem: DM_DEPTH must be a power of 2 in 16..65536");
    end

    logic [DM_WIDTH-1:0] mem_q [DM_DEPTH];

    // Offsets carry one extra bit so addresses below base borrow into the MSB instead of
    // wrapping back into the array.
    logic [DM_WIDTH:0]   wr_off, rd_off;
    logic [AW-1:0]       wr_idx, rd_idx;
    logic                wr_ok, rd_ok, wr_commit;
    logic [DM_WIDTH-1:0] rd_word;
    logic                rd_par_bad;

    assign wr_off    = {1'b0, dm.dm_wr_addr_i} - {1'b0, DM_BASE_ADDR};
    assign rd_off    = {1'b0, dm.dm_rd_addr_i} - {1'b0, DM_BASE_ADDR};
    assign wr_idx    = wr_off[AW+1:2];
    assign rd_idx    = rd_off[AW+1:2];
    assign wr_ok     = (wr_off[DM_WIDTH:AW+2] == '0) && (dm.dm_wr_addr_i[1:0] == 2'b00);
    assign rd_ok     = (rd_off[DM_WIDTH:AW+2] == '0) && (dm.dm_rd_addr_i[1:0] == 2'b00);
    assign wr_commit = dm.dm_wr_en_i && wr_ok && (|dm.dm_wr_strb_i);
    assign rd_word   = mem_q[rd_idx];

    // Low offset bits duplicate the address alignment bits already checked above.
    logic unused_off_bits;
    assign unused_off_bits = ^{wr_off[1:0], rd_off[1:0]};

`ifdef DM_PARITY_EN
    logic [NB-1:0] par_q [DM_DEPTH];
    logic [NB-1:0] rd_par_calc;

    // Parity storage: strobed lanes get even parity, optionally inverted by the inject hook.
    always_ff @(posedge clk_i) begin
        if (wr_commit) begin
            for (int b = 0; b < NB; b++) begin
                if (dm.dm_wr_strb_i[b]) begin
                    par_q[wr_idx][b] <= (^dm.dm_wr_data_i[8*b +: 8]) ^ dm.dm_par_inject_i;
                end
            end
        end
    end

    // Recompute parity of the word being read and compare with what was stored.
    always_comb begin
        rd_par_calc = '0;
        for (int b = 0; b < NB; b++) begin
            rd_par_calc[b] = ^rd_word[8*b +: 8];
        end
    end
    assign rd_par_bad = |(rd_par_calc ^ par_q[rd_idx]);
`else
    logic unused_inject;
    assign unused_inject = dm.dm_par_inject_i;
    assign rd_par_bad    = 1'b0;
`endif

    // Array write: only strobed byte lanes change; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (wr_commit) begin
            for (int b = 0; b < NB; b++) begin
                if (dm.dm_wr_strb_i[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= dm.dm_wr_data_i[8*b +: 8];
                end
            end
        end
    end

    // Stage-0 inputs; a rejected read returns zero data with the error flag set.
    logic                rd_vld_d, rd_err_d, rd_perr_d;
    logic [DM_WIDTH-1:0] rd_data_d;

    assign rd_vld_d  = dm.dm_rd_en_i;
    assign rd_err_d  = dm.dm_rd_en_i && !rd_ok;
    assign rd_perr_d = dm.dm_rd_en_i && rd_ok && rd_par_bad;
    assign rd_data_d = rd_ok ? rd_word : '0;

    logic                pipe_vld_q  [DM_RD_LAT];
    logic                pipe_err_q  [DM_RD_LAT];
    logic                pipe_perr_q [DM_RD_LAT];
    logic [DM_WIDTH-1:0] pipe_data_q [DM_RD_LAT];
    logic                wr_err_q;

    // Read pipeline and write-error pulse; data only moves with a valid so the output holds.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_err_q <= 1'b0;
            for (int k = 0; k < DM_RD_LAT; k++) begin
                pipe_vld_q[k]  <= 1'b0;
                pipe_err_q[k]  <= 1'b0;
                pipe_perr_q[k] <= 1'b0;
                pipe_data_q[k] <= '0;
            end
        end else begin
            wr_err_q       <= dm.dm_wr_en_i && !wr_ok;
            pipe_vld_q[0]  <= rd_vld_d;
            pipe_err_q[0]  <= rd_err_d;
            pipe_perr_q[0] <= rd_perr_d;
            if (rd_vld_d) begin
                pipe_data_q[0] <= rd_data_d;
            end
            for (int k = 1; k < DM_RD_LAT; k++) begin
                pipe_vld_q[k]  <= pipe_vld_q[k-1];
                pipe_err_q[k]  <= pipe_err_q[k-1];
                pipe_perr_q[k] <= pipe_perr_q[k-1];
                if (pipe_vld_q[k-1]) begin
                    pipe_data_q[k] <= pipe_data_q[k-1];
                end
            end
        end
    end

    assign dm.dm_wr_err_o     = wr_err_q;
    assign dm.dm_rd_valid_o   = pipe_vld_q[Last];
    assign dm.dm_rd_err_o     = pipe_err_q[Last];
    assign dm.dm_rd_par_err_o = pipe_perr_q[Last];
    assign dm.dm_rd_data_o    = pipe_data_q[Last];
endmodule

// File: tb/tb_zcore_data_mem.sv
// Self-checking bench for zcore_data_mem: two instances (read latency 1 and 3) share one
// stimulus stream; a reference model fills per-instance expectation queues that a negedge
// monitor drains. Parity expectations follow DM_PARITY_EN when it is defined.
module tb_zcore_data_mem;
    localparam logic [31:0] BASE  = 32'h0004_8120;
    localparam int          DEPTH = 1024;
    localparam int          LAT_A = 1;
    localparam int          LAT_B = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en, rd_en, inject;
    logic [31:0] wr_addr, wr_data, rd_addr;
    logic [3:0]  wr_strb;

    always #5 clk = ~clk;

    zcore_data_mem_if bus_a ();
    zcore_data_mem_if bus_b ();

    assign bus_a.dm_wr_en_i      = wr_en;
    assign bus_a.dm_wr_addr_i    = wr_addr;
    assign bus_a.dm_wr_data_i    = wr_data;
    assign bus_a.dm_wr_strb_i    = wr_strb;
    assign bus_a.dm_rd_en_i      = rd_en;
    assign bus_a.dm_rd_addr_i    = rd_addr;
    assign bus_a.dm_par_inject_i = inject;
    assign bus_b.dm_wr_en_i      = wr_en;
    assign bus_b.dm_wr_addr_i    = wr_addr;
    assign bus_b.dm_wr_data_i    = wr_data;
    assign bus_b.dm_wr_strb_i    = wr_strb;
    assign bus_b.dm_rd_en_i      = rd_en;
    assign bus_b.dm_rd_addr_i    = rd_addr;
    assign bus_b.dm_par_inject_i = inject;

    zcore_data_mem #(.DM_RD_LAT(LAT_A)) u_dut_a (.clk_i(clk), .rst_n_i(rst_n), .dm(bus_a));
    zcore_data_mem #(.DM_RD_LAT(LAT_B)) u_dut_b (.clk_i(clk), .rst_n_i(rst_n), .dm(bus_b));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
        logic        par;
        logic        par_mask;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] mem_m   [DEPTH];
    logic [3:0]  par_m   [DEPTH];
    logic [3:0]  wrote_m [DEPTH];
    logic [31:0] last_d  [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_ok(input logic [31:0] a, output int idx);
        idx = 0;
        if (a < BASE || (a - BASE) >= 32'(4 * DEPTH) || a[1:0] != 2'b00) return 1'b0;
        idx = int'((a - BASE) >> 2);
        return 1'b1;
    endfunction

    function automatic logic [3:0] par_of(input logic [31:0] d);
        return {^d[31:24], ^d[23:16], ^d[15:8], ^d[7:0]};
    endfunction

    // One request cycle: model read-first, then write; check the write-error pulse after the edge.
    task automatic step(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                        input logic [3:0] ws, input logic inj, input logic re,
                        input logic [31:0] ra);
        exp_t e;
        int   ri, wi;
        logic rok, wok, exp_werr;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_strb = ws; inject = inj;
        rd_en = re; rd_addr = ra;
        if (re) begin
            rok    = addr_ok(ra, ri);
            e.err  = !rok;
            e.data = rok ? mem_m[ri] : 32'h0;
`ifdef DM_PARITY_EN
            e.par      = rok && (|(par_m[ri] ^ par_of(mem_m[ri])));
            e.par_mask = rok && (wrote_m[ri] != 4'hF);
`else
            e.par      = 1'b0;
            e.par_mask = 1'b0;
`endif
            e.cyc = cyc + LAT_A;
            q_a.push_back(e);
            e.cyc = cyc + LAT_B;
            q_b.push_back(e);
        end
        wok      = addr_ok(wa, wi);
        exp_werr = we && !wok;
        if (we && wok) begin
            for (int b = 0; b < 4; b++) begin
                if (ws[b]) begin
                    mem_m[wi][8*b +: 8] = wd[8*b +: 8];
                    par_m[wi][b]        = (^wd[8*b +: 8]) ^ inj;
                    wrote_m[wi][b]      = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; inject = 1'b0; wr_strb = 4'h0;
        check("wr_err_a", 32'(bus_a.dm_wr_err_o), 32'(exp_werr));
        check("wr_err_b", 32'(bus_b.dm_wr_err_o), 32'(exp_werr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, a);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic inj);
        step(1'b1, a, d, s, inj, 1'b0, 32'h0);
    endtask

    task automatic mon(input int sel, input logic v, input logic [31:0] d, input logic e,
                       input logic pe);
        exp_t  x;
        string s;
        int    qn;
        s  = (sel == 0) ? "a" : "b";
        qn = (sel == 0) ? q_a.size() : q_b.size();
        if (!rst_n) begin
            check({"rst_valid_", s}, 32'(v), 32'h0);
            check({"rst_data_", s}, d, 32'h0);
            check({"rst_err_", s}, 32'(e), 32'h0);
            check({"rst_perr_", s}, 32'(pe), 32'h0);
            last_d[sel] = 32'h0;
        end else if (v) begin
            if (qn == 0) begin
                check({"unexpected_valid_", s}, 32'(v), 32'h0);
            end else begin
                if (sel == 0) x = q_a.pop_front();
                else          x = q_b.pop_front();
                check({"latency_", s}, 32'(cyc), 32'(x.cyc));
                check({"rd_data_", s}, d, x.data);
                check({"rd_err_", s}, 32'(e), 32'(x.err));
                if (!x.par_mask) check({"rd_perr_", s}, 32'(pe), 32'(x.par));
            end
            last_d[sel] = d;
        end else begin
            check({"hold_data_", s}, d, last_d[sel]);
            check({"idle_err_", s}, 32'(e), 32'h0);
            check({"idle_perr_", s}, 32'(pe), 32'h0);
            if (qn != 0) begin
                x = (sel == 0) ? q_a[0] : q_b[0];
                if (x.cyc <= cyc) begin
                    check({"missing_valid_", s}, 32'(v), 32'h1);
                    if (sel == 0) void'(q_a.pop_front());
                    else          void'(q_b.pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus_a.dm_rd_valid_o, bus_a.dm_rd_data_o, bus_a.dm_rd_err_o,
            bus_a.dm_rd_par_err_o);
        mon(1, bus_b.dm_rd_valid_o, bus_b.dm_rd_data_o, bus_b.dm_rd_err_o,
            bus_b.dm_rd_par_err_o);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = 32'h0; par_m[i] = 4'h0; wrote_m[i] = 4'h0;
        end
        last_d[0] = 32'h0; last_d[1] = 32'h0;
        wr_en = 1'b0; rd_en = 1'b0; inject = 1'b0;
        wr_addr = 32'h0; wr_data = 32'h0; rd_addr = 32'h0; wr_strb = 4'h0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic write then read
        wr(BASE, 32'hDEAD_BEEF, 4'hF, 1'b0);
        rd(BASE);
        // Partial strobes
        wr(BASE + 4, 32'h1122_3344, 4'hF, 1'b0);
        wr(BASE + 4, 32'hAABB_CCDD, 4'b0101, 1'b0);
        rd(BASE + 4);
        // Below base, misaligned, past end
        rd(32'h0004_811C);
        rd(32'h0004_8122);
        wr(BASE + 32'(4 * DEPTH), 32'h1234_5678, 4'hF, 1'b0);
        wr(32'h0000_0000, 32'h1234_5678, 4'hF, 1'b0);
        rd(BASE);
        rd(BASE + 32'(4 * (DEPTH - 1)) + 4);
        // Back-to-back reads with a same-cycle write to the word being read
        wr(BASE + 8,  32'h0102_0304, 4'hF, 1'b0);
        wr(BASE + 12, 32'hCAFE_F00D, 4'hF, 1'b0);
        wr(BASE + 32'(4 * (DEPTH - 1)), 32'h7777_8888, 4'hF, 1'b0);
        rd(BASE);
        step(1'b1, BASE + 4, 32'h0000_0005, 4'hF, 1'b0, 1'b1, BASE + 4);
        rd(BASE + 8);
        rd(BASE + 12);
        rd(BASE + 4);
        rd(BASE + 32'(4 * (DEPTH - 1)));
        // Strobe-0 write is a silent no-op
        step(1'b1, BASE + 8, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b1, BASE + 8);
        rd(BASE + 8);
        // Write error and read in the same cycle
        step(1'b1, BASE + 6, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, BASE + 12);
        rd(BASE + 4);
        // Parity inject hook (ignored when parity is compiled out)
        wr(BASE + 16, 32'h0000_00FF, 4'hF, 1'b1);
        rd(BASE + 16);
        wr(BASE + 16, 32'h0000_00FF, 4'hF, 1'b0);
        rd(BASE + 16);
        wr(BASE + 20, 32'hA5A5_0F0F, 4'hF, 1'b0);
        wr(BASE + 20, 32'h0000_FF00, 4'b0010, 1'b1);
        rd(BASE + 20);
        idle(5);

        // Reset with reads in flight: nothing may emerge afterwards
        rd(BASE);
        rd(BASE + 4);
        rst_n = 1'b0;
        q_a.delete();
        q_b.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(8);
        rd(BASE + 12);
        idle(5);

        check("q_a_drained", 32'(q_a.size()), 32'h0);
        check("q_b_drained", 32'(q_b.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/zcore_data_mem.md
Name: zcore_data_mem

Overview:
- Parametrised, clocked data memory for ZCore, the successor to the flat word-array bench memory.
- Serves the core's load/store port. Translates byte addresses to word indices relative to a configurable base address.
- Supports byte-strobed writes and a pipelined read path with configurable latency.
- Flags out-of-range and misaligned accesses instead of silently aliasing them.

Parameters:
- DM_WIDTH, 32, data and address width in bits; must be 32.
- DM_DEPTH, 1024, number of words; must be a power of 2, 16..65536.
- DM_BASE_ADDR, 32'h0004_8120, byte address of word 0.
- DM_RD_LAT, 1, read latency in cycles from request to data; legal range 1..4.

Ports:
- clk_i  in  1  core clock; all state updates on its rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- dm_wr_en_i  in  1  write request, one cycle.
- dm_wr_addr_i  in  DM_WIDTH  write byte address.
- dm_wr_data_i  in  DM_WIDTH  write data.
- dm_wr_strb_i  in  DM_WIDTH/8  byte lane enables; bit n enables byte n.
- dm_wr_err_o  out  1  one-cycle pulse; the previous cycle's write was rejected.
- dm_rd_en_i  in  1  read request, one cycle.
- dm_rd_addr_i  in  DM_WIDTH  read byte address.
- dm_rd_data_o  out  DM_WIDTH  read data; valid when dm_rd_valid_o is high.
- dm_rd_valid_o  out  1  read data valid pulse.
- dm_rd_err_o  out  1  read rejected; coincident with dm_rd_valid_o.
- dm_rd_par_err_o  out  1  parity mismatch on returned word; coincident with dm_rd_valid_o.
- dm_par_inject_i  in  1  test hook: corrupt the parity stored by this cycle's write.

Behaviour:
- Reset:
  - Asynchronous assert, synchronous deassert, taken externally.
  - All outputs drive 0; the read pipeline valid bits clear.
  - Array contents are not reset.
- Address map:
  - idx = (addr - DM_BASE_ADDR) >> 2.
  - An access is in range iff addr >= DM_BASE_ADDR and idx < DM_DEPTH.
  - Misaligned iff addr[1:0] != 0.
  - Subtraction is done in DM_WIDTH+1 bits so addresses below base never wrap into range.
- Write:
  - Accepted at the rising edge when dm_wr_en_i=1, the access is in range and aligned, and dm_wr_strb_i != 0.
  - Only strobed bytes update.
  - A write with strobe 0 is a legal no-op (no error).
  - An out-of-range or misaligned write leaves the array unchanged and asserts dm_wr_err_o for exactly one cycle, starting the cycle after the request.
- Read:
  - Fully pipelined; one request per cycle is accepted with no back-pressure.
  - The array is sampled at the accepting edge.
  - dm_rd_valid_o pulses exactly DM_RD_LAT cycles after the request cycle.
  - Back-to-back requests produce back-to-back valids, in order.
- Read error: an out-of-range or misaligned read still produces dm_rd_valid_o at normal latency, with dm_rd_err_o=1 and dm_rd_data_o=0.
- Outputs between valids: dm_rd_data_o holds its last value; dm_rd_err_o and dm_rd_par_err_o are 0.
- Simultaneous write and read to the same word in the same cycle: read-first; the read returns pre-write data. The write is visible to any read issued the following cycle.
- Simultaneous write error and read: independent; both are reported.
- Reset mid-operation: in-flight reads are discarded, no valid is emitted after reset release, and a write coinciding with reset assertion is not guaranteed to commit.
- Parameter checks: DM_RD_LAT outside 1..4 or DM_DEPTH not a power of 2 triggers an elaboration-time $error.

Optional Feature:
- Macro DM_PARITY_EN.
- When defined:
  - One even-parity bit is stored per byte; a strobed byte's parity updates with its data.
  - dm_par_inject_i=1 inverts the stored parity of every strobed byte in that write.
  - On read, stored parity is recomputed over all 4 bytes; dm_rd_par_err_o=1 with dm_rd_valid_o if any byte mismatches. Data is still returned.
  - Parity bits are not reset. A read of a never-written word gives an undefined dm_rd_par_err_o, which the bench must mask.
- When undefined: no parity storage, dm_rd_par_err_o tied 0, dm_par_inject_i ignored.

Test Plan:
- Write 0xDEADBEEF to 0x48120 with strb 4'hF, then read 0x48120 → with DM_RD_LAT=1: valid one cycle after the read, data 0xDEADBEEF, err 0.
- Write 0x11223344 to 0x48124 (strb F), then 0xAABBCCDD (strb 4'b0101), then read → 0x11BB33DD.
- Read 0x4811C (below base), read 0x48122 (misaligned), write to 0x48120+4*DM_DEPTH → two read valids with err=1 and data 0; one dm_wr_err_o pulse; array unchanged.
- With DM_RD_LAT=3, four consecutive reads of 0x48120..0x4812C → four consecutive valids starting 3 cycles after the first request, in order. Same-cycle write 0x5 to 0x48124 with the read of 0x48124 returns old data; a re-read returns 0x5.
- Issue two reads, assert rst_n_i=0 the next cycle for 2 cycles → no dm_rd_valid_o observed after release; all outputs 0 during reset.
- DM_PARITY_EN: write 0x000000FF with dm_par_inject_i=1, then read → data 0x000000FF, dm_rd_par_err_o=1. Rewrite without inject, then read → dm_rd_par_err_o=0.
